// File: rtl/pe_driver_if.sv
// Bundle of operand-buffer, PE and result handshake signals around pe_driver.
// master = the sequencer, slave = the surrounding buffers/PE/consumer.
interface pe_driver_if #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 10
);
    logic                  i_start;
    logic [LEN_WIDTH-1:0]  i_len;
    logic [ADDR_WIDTH-1:0] i_data_base;
    logic [ADDR_WIDTH-1:0] i_weight_base;
    logic [BIT_WIDTH-1:0]  i_bias;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_data_addr;
    logic [ADDR_WIDTH-1:0] o_weight_addr;
    logic [BIT_WIDTH-1:0]  i_data_rdata;
    logic [BIT_WIDTH-1:0]  i_weight_rdata;
    logic [BIT_WIDTH-1:0]  o_pe_data;
    logic                  o_pe_data_val;
    logic [BIT_WIDTH-1:0]  o_pe_weight;
    logic                  o_pe_weight_val;
    logic [BIT_WIDTH-1:0]  o_pe_psum;
    logic                  o_pe_psum_val;
    logic [BIT_WIDTH-1:0]  i_pe_psum;
    logic                  i_pe_psum_val;
    logic [BIT_WIDTH-1:0]  o_result;
    logic                  o_result_val;
    logic                  i_result_rdy;
    logic                  o_busy;
    logic                  o_err;

    modport master (
        input  i_start, i_len, i_data_base, i_weight_base, i_bias,
        input  i_data_rdata, i_weight_rdata, i_pe_psum, i_pe_psum_val, i_result_rdy,
        output o_rd_en, o_data_addr, o_weight_addr,
        output o_pe_data, o_pe_data_val, o_pe_weight, o_pe_weight_val, o_pe_psum, o_pe_psum_val,
        output o_result, o_result_val, o_busy, o_err
    );

    modport slave (
        output i_start, i_len, i_data_base, i_weight_base, i_bias,
        output i_data_rdata, i_weight_rdata, i_pe_psum, i_pe_psum_val, i_result_rdy,
        input  o_rd_en, o_data_addr, o_weight_addr,
        input  o_pe_data, o_pe_data_val, o_pe_weight, o_pe_weight_val, o_pe_psum, o_pe_psum_val,
        input  o_result, o_result_val, o_busy, o_err
    );
endinterface

// File: rtl/pe_driver.sv
// Serial dot-product sequencer for one MAC PE: fetch operand pair, issue to PE,
// fold the returned psum back as the next i_psum, then present the final sum.
module pe_driver #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 10,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    pe_driver_if.master   bus
);
    localparam int unsigned CNT_MAX = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT_RD, S_ISSUE, S_WAIT_PSUM, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, idx_q, idx_d, idx_inc;
    logic [ADDR_WIDTH-1:0] dbase_q, dbase_d, wbase_q, wbase_d;
    logic [BIT_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d, waddr_q, waddr_d;
    logic [BIT_WIDTH-1:0]  pe_data_q, pe_data_d, pe_weight_q, pe_weight_d, pe_psum_q, pe_psum_d;
    logic                  pe_val_q, pe_val_d;
    logic [BIT_WIDTH-1:0]  result_q, result_d;
    logic                  result_val_q, result_val_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            dbase_q      <= '0;
            wbase_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rd_en_q      <= 1'b0;
            daddr_q      <= '0;
            waddr_q      <= '0;
            pe_data_q    <= '0;
            pe_weight_q  <= '0;
            pe_psum_q    <= '0;
            pe_val_q     <= 1'b0;
            result_q     <= '0;
            result_val_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            dbase_q      <= dbase_d;
            wbase_q      <= wbase_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rd_en_q      <= rd_en_d;
            daddr_q      <= daddr_d;
            waddr_q      <= waddr_d;
            pe_data_q    <= pe_data_d;
            pe_weight_q  <= pe_weight_d;
            pe_psum_q    <= pe_psum_d;
            pe_val_q     <= pe_val_d;
            result_q     <= result_d;
            result_val_q <= result_val_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        dbase_d     = dbase_q;
        wbase_d     = wbase_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        pe_data_d   = pe_data_q;
        pe_weight_d = pe_weight_q;
        idx_inc     = idx_q + LEN_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    len_d   = bus.i_len;
                    dbase_d = bus.i_data_base;
                    wbase_d = bus.i_weight_base;
                    acc_d   = bus.i_bias;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = (bus.i_len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                cnt_d   = '0;
                state_d = S_WAIT_RD;
            end
            // Read data is captured straight into the PE operand registers on its valid cycle.
            S_WAIT_RD: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    pe_data_d   = bus.i_data_rdata;
                    pe_weight_d = bus.i_weight_rdata;
                    state_d     = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_PSUM;
            end
            // A valid arriving on the expiry cycle still counts as a good return.
            S_WAIT_PSUM: begin
                if (bus.i_pe_psum_val) begin
                    acc_d   = bus.i_pe_psum;
                    idx_d   = idx_inc;
                    state_d = (idx_inc == len_q) ? S_DONE : S_RD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.i_result_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Output registers are loaded from the next state so they line up with the state itself.
        rd_en_d      = (state_d == S_RD);
        daddr_d      = rd_en_d ? dbase_d + ADDR_WIDTH'(idx_d) : '0;
        waddr_d      = rd_en_d ? wbase_d + ADDR_WIDTH'(idx_d) : '0;
        pe_val_d     = (state_d == S_ISSUE);
        pe_psum_d    = pe_val_d ? acc_q : pe_psum_q;
        result_val_d = (state_d == S_DONE);
        result_d     = result_val_d ? acc_d : '0;
        busy_d       = (state_d != S_IDLE);
    end

    assign bus.o_rd_en         = rd_en_q;
    assign bus.o_data_addr     = daddr_q;
    assign bus.o_weight_addr   = waddr_q;
    assign bus.o_pe_data       = pe_data_q;
    assign bus.o_pe_weight     = pe_weight_q;
    assign bus.o_pe_psum       = pe_psum_q;
    assign bus.o_pe_data_val   = pe_val_q;
    assign bus.o_pe_weight_val = pe_val_q;
    assign bus.o_pe_psum_val   = pe_val_q;
    assign bus.o_result        = result_q;
    assign bus.o_result_val    = result_val_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_err           = err_q;
endmodule

// File: tb/tb_pe_driver.sv
// Directed bench for pe_driver with a one-cycle-latency operand buffer model and a
// fixed-latency MAC PE model (o_psum = data*weight + i_psum).
module tb_pe_driver;
    localparam int unsigned BW = 8, AW = 10, LW = 10, RD_LAT = 1, TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_driver_if #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    pe_driver #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT))
        dut (.clk(clk), .rst(rst), .bus(bus));

    logic [BW-1:0] dmem [0:(1<<AW)-1];
    logic [BW-1:0] wmem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Operand buffers: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.o_rd_en) begin
            bus.i_data_rdata   <= dmem[bus.o_data_addr];
            bus.i_weight_rdata <= wmem[bus.o_weight_addr];
        end else begin
            bus.i_data_rdata   <= 8'hEE;
            bus.i_weight_rdata <= 8'hEE;
        end
    end

    // PE model: returns product plus the current i_psum pe_lat cycles after issue.
    int            pe_lat  = 4;
    bit            pe_mute = 1'b0;
    int            pe_cnt  = 0;
    logic [BW-1:0] pe_prod = '0;
    always @(posedge clk) begin
        bus.i_pe_psum_val <= 1'b0;
        if (bus.o_pe_data_val && !pe_mute) begin
            pe_prod <= bus.o_pe_data * bus.o_pe_weight;
            pe_cnt  <= pe_lat;
        end else if (pe_cnt > 1) begin
            pe_cnt <= pe_cnt - 1;
        end else if (pe_cnt == 1) begin
            pe_cnt            <= 0;
            bus.i_pe_psum_val <= 1'b1;
            bus.i_pe_psum     <= pe_prod + bus.o_pe_psum;
        end
    end

    // Activity monitors; tests look at deltas across a job.
    int            issue_cnt = 0, rd_cnt = 0, res_cnt = 0, valmis = 0;
    logic [AW-1:0] daddr_log [$];
    logic [AW-1:0] waddr_log [$];
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.o_pe_data_val) issue_cnt++;
            if ((bus.o_pe_data_val !== bus.o_pe_weight_val) || (bus.o_pe_data_val !== bus.o_pe_psum_val)) valmis++;
            if (bus.o_rd_en) begin
                rd_cnt++;
                daddr_log.push_back(bus.o_data_addr);
                waddr_log.push_back(bus.o_weight_addr);
            end
            if (bus.o_result_val && bus.i_result_rdy) res_cnt++;
        end
    end

    task automatic start_job(input logic [LW-1:0] len, input logic [AW-1:0] db, input logic [AW-1:0] wb,
                             input logic [BW-1:0] bias);
        bus.i_len         = len;
        bus.i_data_base   = db;
        bus.i_weight_base = wb;
        bus.i_bias        = bias;
        bus.i_start       = 1'b1;
        @(negedge clk);
        bus.i_start       = 1'b0;
    endtask

    task automatic wait_result(input int max, output bit got, output logic [BW-1:0] val);
        got = 1'b0;
        val = '0;
        for (int i = 0; i < max; i++) begin
            if (bus.o_result_val) begin
                got = 1'b1;
                val = bus.o_result;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if ({bus.o_busy, bus.o_rd_en, bus.o_pe_data_val, bus.o_result_val, bus.o_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.o_busy, bus.o_rd_en, bus.o_pe_data_val, bus.o_result_val, bus.o_err});
        end
        n_checks++;
        if ({bus.o_pe_psum, bus.o_result, bus.o_data_addr} !== '0) begin
            n_fail++; $display("FAIL reset_values: psum %h result %h addr %h expected all 0",
                bus.o_pe_psum, bus.o_result, bus.o_data_addr);
        end
        n_checks++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        if (bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy %b expected 0", bus.o_busy);
        end
        n_checks++;
    endtask

    task automatic test_dot3();
        bit got; logic [BW-1:0] val;
        int i0 = issue_cnt, r0 = res_cnt;
        dmem[10'h010] = 8'd1; dmem[10'h011] = 8'd2; dmem[10'h012] = 8'd3;
        wmem[10'h020] = 8'd4; wmem[10'h021] = 8'd5; wmem[10'h022] = 8'd6;
        start_job(10'd3, 10'h010, 10'h020, 8'h00);
        if (bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL dot3_busy: got %b expected 1", bus.o_busy);
        end
        n_checks++;
        wait_result(200, got, val);
        if (got !== 1'b1 || val !== 8'h20) begin
            n_fail++; $display("FAIL dot3_result: got valid %b value %h expected 1 / 20", got, val);
        end
        n_checks++;
        repeat (3) @(negedge clk);
        if (issue_cnt - i0 != 3) begin
            n_fail++; $display("FAIL dot3_issues: got %0d expected 3", issue_cnt - i0);
        end
        n_checks++;
        if (res_cnt - r0 != 1) begin
            n_fail++; $display("FAIL dot3_results: got %0d expected 1", res_cnt - r0);
        end
        n_checks++;
        if (valmis != 0) begin
            n_fail++; $display("FAIL pe_valids_aligned: got %0d misaligned cycles expected 0", valmis);
        end
        n_checks++;
    endtask

    task automatic test_wrap_mult();
        bit got; logic [BW-1:0] val;
        dmem[10'h030] = 8'h80; wmem[10'h040] = 8'h02;
        start_job(10'd1, 10'h030, 10'h040, 8'h05);
        wait_result(200, got, val);
        if (got !== 1'b1 || val !== 8'h05) begin
            n_fail++; $display("FAIL wrap_mult: got valid %b value %h expected 1 / 05", got, val);
        end
        n_checks++;
    endtask

    task automatic test_len_zero();
        bit got; logic [BW-1:0] val;
        int i0 = issue_cnt, rd0 = rd_cnt;
        start_job(10'd0, 10'h000, 10'h000, 8'h7A);
        wait_result(50, got, val);
        if (got !== 1'b1 || val !== 8'h7A) begin
            n_fail++; $display("FAIL len_zero_result: got valid %b value %h expected 1 / 7a", got, val);
        end
        n_checks++;
        if ((rd_cnt - rd0) != 0 || (issue_cnt - i0) != 0) begin
            n_fail++; $display("FAIL len_zero_quiet: got %0d reads %0d issues expected 0 0", rd_cnt - rd0, issue_cnt - i0);
        end
        n_checks++;
    endtask

    task automatic test_addr_wrap();
        bit got; logic [BW-1:0] val;
        logic [AW-1:0] exp_d [4];
        logic [AW-1:0] exp_w [4];
        int base = daddr_log.size();
        exp_d[0] = 10'h3FE; exp_d[1] = 10'h3FF; exp_d[2] = 10'h000; exp_d[3] = 10'h001;
        exp_w[0] = 10'h100; exp_w[1] = 10'h101; exp_w[2] = 10'h102; exp_w[3] = 10'h103;
        dmem[10'h3FE] = 8'd1; dmem[10'h3FF] = 8'd2; dmem[10'h000] = 8'd3; dmem[10'h001] = 8'd4;
        for (int k = 0; k < 4; k++) wmem[exp_w[k]] = 8'd1;
        start_job(10'd4, 10'h3FE, 10'h100, 8'h00);
        wait_result(200, got, val);
        if (got !== 1'b1 || val !== 8'h0A) begin
            n_fail++; $display("FAIL addr_wrap_result: got valid %b value %h expected 1 / 0a", got, val);
        end
        n_checks++;
        if (daddr_log.size() - base != 4) begin
            n_fail++; $display("FAIL addr_wrap_reads: got %0d expected 4", daddr_log.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (daddr_log[base+k] !== exp_d[k] || waddr_log[base+k] !== exp_w[k]) begin
                    n_fail++; $display("FAIL addr_wrap_%0d: got %h/%h expected %h/%h", k,
                        daddr_log[base+k], waddr_log[base+k], exp_d[k], exp_w[k]);
                end
                n_checks++;
            end
        end
        n_checks++;
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        bit got; logic [BW-1:0] val;
        int r0 = res_cnt;
        pe_mute = 1'b1;
        dmem[10'h050] = 8'h03; wmem[10'h060] = 8'h03;
        start_job(10'd2, 10'h050, 10'h060, 8'h00);
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.o_pe_data_val) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_fail++; $display("FAIL timeout_issue_seen: got 0 expected 1");
        end
        n_checks++;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k == TIMEOUT) begin
                if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_early: err %b busy %b expected 0 1", bus.o_err, bus.o_busy);
                end
                n_checks++;
            end
        end
        if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_expire: err %b busy %b expected 1 0", bus.o_err, bus.o_busy);
        end
        n_checks++;
        repeat (5) @(negedge clk);
        if (res_cnt - r0 != 0 || bus.o_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_no_result: results %0d err %b expected 0 1", res_cnt - r0, bus.o_err);
        end
        n_checks++;
        pe_mute = 1'b0;
        start_job(10'd0, 10'h000, 10'h000, 8'h11);
        if (bus.o_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear_on_start: got %b expected 0", bus.o_err);
        end
        n_checks++;
        wait_result(50, got, val);
    endtask

    task automatic test_valid_at_expiry();
        bit got; logic [BW-1:0] val;
        pe_lat = TIMEOUT - 1;
        dmem[10'h070] = 8'h03; wmem[10'h080] = 8'h03;
        start_job(10'd1, 10'h070, 10'h080, 8'h01);
        wait_result(200, got, val);
        if (got !== 1'b1 || val !== 8'h0A || bus.o_err !== 1'b0) begin
            n_fail++; $display("FAIL valid_at_expiry: got valid %b value %h err %b expected 1 0a 0", got, val, bus.o_err);
        end
        n_checks++;
        pe_lat = 4;
    endtask

    task automatic test_back_pressure();
        bit seen = 1'b0;
        int r0 = res_cnt;
        dmem[10'h090] = 8'h02; wmem[10'h0A0] = 8'h07;
        bus.i_result_rdy = 1'b0;
        start_job(10'd1, 10'h090, 10'h0A0, 8'h00);
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.o_result_val) seen = 1'b1;
            else @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            if (bus.o_result_val !== 1'b1 || bus.o_result !== 8'h0E) begin
                n_fail++; $display("FAIL hold_cycle_%0d: got valid %b value %h expected 1 0e", c, bus.o_result_val, bus.o_result);
            end
            n_checks++;
            bus.i_start = (c == 2);
            bus.i_len   = 10'd0;
            bus.i_bias  = 8'h99;
            @(negedge clk);
        end
        bus.i_start      = 1'b0;
        bus.i_result_rdy = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        if (bus.o_result_val !== 1'b0 || bus.o_busy !== 1'b0 || res_cnt - r0 != 1) begin
            n_fail++; $display("FAIL start_in_done_ignored: valid %b busy %b results %0d expected 0 0 1",
                bus.o_result_val, bus.o_busy, res_cnt - r0);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int r0 = res_cnt;
        dmem[10'h0B0] = 8'h11; wmem[10'h0C0] = 8'h22;
        start_job(10'd2, 10'h0B0, 10'h0C0, 8'h33);
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.o_pe_data_val) seen = 1'b1;
            else @(negedge clk);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if ({bus.o_busy, bus.o_rd_en, bus.o_pe_data_val, bus.o_result_val, bus.o_err,
             bus.o_pe_data, bus.o_pe_weight, bus.o_pe_psum, bus.o_result, bus.o_data_addr} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: busy %b data %h weight %h psum %h expected all 0",
                bus.o_busy, bus.o_pe_data, bus.o_pe_weight, bus.o_pe_psum);
        end
        n_checks++;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        if (res_cnt - r0 != 0 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_abort: results %0d busy %b expected 0 0", res_cnt - r0, bus.o_busy);
        end
        n_checks++;
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_len = '0; bus.i_data_base = '0; bus.i_weight_base = '0;
        bus.i_bias = '0; bus.i_result_rdy = 1'b1;
        @(negedge clk);
        test_reset();
        test_dot3();
        test_wrap_mult();
        test_len_zero();
        test_addr_wrap();
        test_timeout();
        test_valid_at_expiry();
        test_back_pressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
